muntjac_fpu_round_pipe: RTL and testbench

Parametrised, pipelined rounding and renormalisation stage for the FPU back end. It accepts an unrounded normalised significand carrying a round bit and a sticky bit, together with sign, exponent and rounding mode. It produces the rounded significand, the adjusted exponent, and overflow saturation to infinity or to max-finite. It also keeps sticky NX/OF exception flags for the CSR path. It sits between the arithmetic datapaths (add, mul, div, sqrt) and result packing. Fixed 2-cycle latency, full throughput, valid/ready on both sides.

---
 rtl/muntjac_fpu_round_pipe.sv | 186 ++++++++++++++++++
 tb/tb_muntjac_fpu_round_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muntjac_fpu_round_pipe.sv
// Two-stage rounding and renormalisation pipeline for the FPU back end.
// Stage 1 decides the round-up and increments; stage 2 renormalises and saturates.
module muntjac_fpu_round_pipe #(
   parameter int unsigned SigWidth = 24,
   parameter int unsigned ExpWidth = 10,
   parameter int unsigned MaxExp   = 255
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [2:0]          in_rm_i,
   input  logic                in_sign_i,
   input  logic [ExpWidth-1:0] in_exp_i,
   input  logic [SigWidth+1:0] in_sig_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                out_sign_o,
   output logic [ExpWidth-1:0] out_exp_o,
   output logic [SigWidth-1:0] out_sig_o,
   output logic                out_inexact_o,
   output logic                out_overflow_o,
   output logic [1:0]          flags_o,
   input  logic                flags_clear_i
);

   localparam logic [ExpWidth-1:0]        MaxExpW    = ExpWidth'(MaxExp);
   localparam logic [ExpWidth-1:0]        MaxFinExpW = ExpWidth'(MaxExp - 1);
   localparam logic signed [ExpWidth:0]   MaxExpExt  = (ExpWidth+1)'(MaxExp);

   function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                     input logic l, input logic r, input logic s);
      logic up;
      case (rm)
         3'd0:    up = r & (s | l);
         3'd2:    up = sign & (r | s);
         3'd3:    up = ~sign & (r | s);
         3'd4:    up = r;
         default: up = 1'b0;
      endcase
      return up;
   endfunction

   function automatic logic sat_to_inf(input logic [2:0] rm, input logic sign);
      logic inf;
      case (rm)
         3'd0, 3'd4: inf = 1'b1;
         3'd2:       inf = sign;
         3'd3:       inf = ~sign;
         default:    inf = 1'b0;
      endcase
      return inf;
   endfunction

   logic                s1_valid_q, s1_valid_d;
   logic                s2_valid_q, s2_valid_d;
   logic                s1_en_s, s2_en_s;
   logic [SigWidth:0]   s1_sig_q, s1_sig_d;
   logic                s1_sign_q, s1_inexact_q;
   logic [ExpWidth-1:0] s1_exp_q;
   logic [2:0]          s1_rm_q;
   logic                out_sign_q, out_inexact_q, out_overflow_q;
   logic [ExpWidth-1:0] out_exp_q, out_exp_d;
   logic [SigWidth-1:0] out_sig_q, out_sig_d;
   logic                out_inexact_d, out_overflow_d;
   logic [1:0]          flags_q, flags_d;
   logic                carry_s;
   logic [ExpWidth:0]   exp_ext_s;
   logic [SigWidth-1:0] norm_sig_s;

   // A stage may load when it is empty or its successor is draining it.
   always_comb begin
      s2_en_s    = ~s2_valid_q | out_ready_i;
      s1_en_s    = ~s1_valid_q | s2_en_s;
      s1_valid_d = s1_en_s ? in_valid_i : s1_valid_q;
      s2_valid_d = s2_en_s ? s1_valid_q : s2_valid_q;
      s1_sig_d   = {1'b0, in_sig_i[SigWidth+1:2]}
                 + {{SigWidth{1'b0}}, round_up(in_rm_i, in_sign_i, in_sig_i[2],
                                               in_sig_i[1], in_sig_i[0])};
   end

   // Stage valid registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // Stage 1 data: incremented significand plus operand context.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_sig_q     <= '0;
         s1_sign_q    <= 1'b0;
         s1_exp_q     <= '0;
         s1_rm_q      <= 3'd0;
         s1_inexact_q <= 1'b0;
      end else if (s1_en_s && in_valid_i) begin
         s1_sig_q     <= s1_sig_d;
         s1_sign_q    <= in_sign_i;
         s1_exp_q     <= in_exp_i;
         s1_rm_q      <= in_rm_i;
         s1_inexact_q <= in_sig_i[1] | in_sig_i[0];
      end else begin
         s1_sig_q     <= s1_sig_q;
         s1_sign_q    <= s1_sign_q;
         s1_exp_q     <= s1_exp_q;
         s1_rm_q      <= s1_rm_q;
         s1_inexact_q <= s1_inexact_q;
      end
   end

   // Carry-out of the increment means the significand was all ones: shift and bump exponent.
   always_comb begin
      carry_s        = s1_sig_q[SigWidth];
      norm_sig_s     = carry_s ? s1_sig_q[SigWidth:1] : s1_sig_q[SigWidth-1:0];
      exp_ext_s      = {s1_exp_q[ExpWidth-1], s1_exp_q} + {{ExpWidth{1'b0}}, carry_s};
      out_overflow_d = $signed(exp_ext_s) >= $signed(MaxExpExt);
      out_inexact_d  = s1_inexact_q | out_overflow_d;
      if (!out_overflow_d) begin
         out_exp_d = exp_ext_s[ExpWidth-1:0];
         out_sig_d = norm_sig_s;
      end else if (sat_to_inf(s1_rm_q, s1_sign_q)) begin
         out_exp_d = MaxExpW;
         out_sig_d = '0;
      end else begin
         out_exp_d = MaxFinExpW;
         out_sig_d = '1;
      end
   end

   // Stage 2 output registers, held while the consumer stalls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_sign_q     <= 1'b0;
         out_exp_q      <= '0;
         out_sig_q      <= '0;
         out_inexact_q  <= 1'b0;
         out_overflow_q <= 1'b0;
      end else if (s2_en_s && s1_valid_q) begin
         out_sign_q     <= s1_sign_q;
         out_exp_q      <= out_exp_d;
         out_sig_q      <= out_sig_d;
         out_inexact_q  <= out_inexact_d;
         out_overflow_q <= out_overflow_d;
      end else begin
         out_sign_q     <= out_sign_q;
         out_exp_q      <= out_exp_q;
         out_sig_q      <= out_sig_q;
         out_inexact_q  <= out_inexact_q;
         out_overflow_q <= out_overflow_q;
      end
   end

   // Flags from a retiring result survive a coincident clear.
   always_comb begin
      flags_d = flags_clear_i ? 2'b00 : flags_q;
      if (s2_valid_q && out_ready_i) begin
         flags_d = flags_d | {out_overflow_q, out_inexact_q};
      end else begin
         flags_d = flags_d;
      end
   end

   // Sticky exception flag register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flags_q <= 2'b00;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign in_ready_o     = s1_en_s;
   assign out_valid_o    = s2_valid_q;
   assign out_sign_o     = out_sign_q;
   assign out_exp_o      = out_exp_q;
   assign out_sig_o      = out_sig_q;
   assign out_inexact_o  = out_inexact_q;
   assign out_overflow_o = out_overflow_q;
   assign flags_o        = flags_q;

endmodule

// File: tb/tb_muntjac_fpu_round_pipe.sv
// Bench for muntjac_fpu_round_pipe: directed vector table, handshake sequences,
// and randomized traffic scored against an arithmetic rounding model.
module tb_muntjac_fpu_round_pipe;

   typedef struct {
      logic [2:0]  rm;
      logic        sign;
      logic [9:0]  e;
      logic [23:0] sig;
      logic        r;
      logic        s;
   } op_t;

   typedef struct {
      logic        sign;
      logic [9:0]  e;
      logic [23:0] sig;
      logic        nx;
      logic        of;
      int          cyc;
   } exp_t;

   typedef struct {
      op_t  op;
      exp_t ex;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [2:0]  in_rm_i = 3'd0;
   logic        in_sign_i = 1'b0;
   logic [9:0]  in_exp_i = 10'd0;
   logic [25:0] in_sig_i = 26'd0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic        out_sign_o;
   logic [9:0]  out_exp_o;
   logic [23:0] out_sig_o;
   logic        out_inexact_o;
   logic        out_overflow_o;
   logic [1:0]  flags_o;
   logic        flags_clear_i = 1'b0;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   pops = 0;
   logic lat_exact = 1'b1;
   logic clear_on_pop = 1'b0;
   logic [1:0] flags_m = 2'b00;
   exp_t sb[$];
   vec_t vecs[$];
   op_t  idle_op;

   muntjac_fpu_round_pipe #(.SigWidth(24), .ExpWidth(10), .MaxExp(255)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_rm_i(in_rm_i), .in_sign_i(in_sign_i), .in_exp_i(in_exp_i), .in_sig_i(in_sig_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_sign_o(out_sign_o),
      .out_exp_o(out_exp_o), .out_sig_o(out_sig_o), .out_inexact_o(out_inexact_o),
      .out_overflow_o(out_overflow_o), .flags_o(flags_o), .flags_clear_i(flags_clear_i)
   );

   always #5 clk_i = ~clk_i;

   // Reference: treat {R,S} as the discarded fraction (below/at/above half) and round the value.
   function automatic exp_t model(input op_t op);
      exp_t x;
      int   m;
      int   e;
      logic half, above, any, up, inf;
      half  = op.r && !op.s;
      above = op.r && op.s;
      any   = op.r || op.s;
      case (op.rm)
         3'd0:    up = above || (half && (op.sig % 2 == 1));
         3'd2:    up = op.sign && any;
         3'd3:    up = !op.sign && any;
         3'd4:    up = op.r;
         default: up = 1'b0;
      endcase
      m = int'(op.sig) + (up ? 1 : 0);
      e = int'($signed(op.e));
      if (m >= (1 << 24)) begin
         m = m / 2;
         e = e + 1;
      end
      x.sign = op.sign;
      x.of   = (e >= 255);
      x.nx   = any || x.of;
      x.cyc  = 0;
      if (x.of) begin
         inf = (op.rm == 3'd0) || (op.rm == 3'd4) || (op.rm == 3'd2 && op.sign) ||
               (op.rm == 3'd3 && !op.sign);
         e   = inf ? 255 : 254;
         m   = inf ? 0 : 24'hFFFFFF;
      end
      x.e   = 10'(e);
      x.sig = 24'(m);
      return x;
   endfunction

   function automatic op_t mkop(input int rm, input logic sign, input int e,
                                input logic [23:0] sig, input logic r, input logic s);
      op_t o;
      o.rm = 3'(rm); o.sign = sign; o.e = 10'(e); o.sig = sig; o.r = r; o.s = s;
      return o;
   endfunction

   function automatic vec_t mkv(input op_t o, input int xe, input logic [23:0] xsig,
                                input logic nx, input logic of);
      vec_t v;
      v.op = o;
      v.ex.sign = o.sign; v.ex.e = 10'(xe); v.ex.sig = xsig;
      v.ex.nx = nx; v.ex.of = of; v.ex.cyc = 0;
      return v;
   endfunction

   function automatic op_t rnd_op();
      op_t o;
      int  e;
      o.rm   = 3'($urandom_range(0, 7));
      o.sign = 1'($urandom_range(0, 1));
      e      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 258))
                                           : int'($urandom_range(0, 230)) - 30;
      o.e    = 10'(e);
      o.sig  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : (24'h800000 | 24'($urandom));
      o.r    = 1'($urandom_range(0, 1));
      o.s    = 1'($urandom_range(0, 1));
      return o;
   endfunction

   // One clock: entered just after a negedge, drives inputs, scores handshakes, ends at next negedge.
   task automatic cycle(input logic v, input op_t op, input exp_t ex, input logic rdy,
                        input logic clr, output logic acc);
      exp_t got;
      tests++;
      if (flags_o !== flags_m) begin
         fails++;
         $display("FAIL flags cyc=%0d got=%b exp=%b", cyc, flags_o, flags_m);
      end
      in_valid_i  = v;
      in_rm_i     = op.rm;
      in_sign_i   = op.sign;
      in_exp_i    = op.e;
      in_sig_i    = {op.sig, op.r, op.s};
      out_ready_i = rdy;
      flags_clear_i = clr;
      #1;
      if (clear_on_pop && out_valid_o && rdy) flags_clear_i = 1'b1;
      acc = 1'b0;
      if (out_valid_o && rdy) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL spurious_output cyc=%0d got sig=%h exp=none", cyc, out_sig_o);
         end else begin
            got = sb.pop_front();
            pops++;
            if ({out_sign_o, out_exp_o, out_sig_o, out_inexact_o, out_overflow_o} !==
                {got.sign, got.e, got.sig, got.nx, got.of}) begin
               fails++;
               $display("FAIL result cyc=%0d got s=%b e=%0d sig=%h nx=%b of=%b exp s=%b e=%0d sig=%h nx=%b of=%b",
                        cyc, out_sign_o, $signed(out_exp_o), out_sig_o, out_inexact_o, out_overflow_o,
                        got.sign, $signed(got.e), got.sig, got.nx, got.of);
            end
            tests++;
            if (lat_exact ? (cyc - got.cyc != 2) : (cyc - got.cyc < 2)) begin
               fails++;
               $display("FAIL latency cyc=%0d got=%0d exp=%s2", cyc, cyc - got.cyc,
                        lat_exact ? "" : ">=");
            end
            flags_m = (flags_clear_i ? 2'b00 : flags_m) | {got.of, got.nx};
         end
      end else if (flags_clear_i) begin
         flags_m = 2'b00;
      end
      if (v && in_ready_o) begin
         got = ex;
         got.cyc = cyc;
         sb.push_back(got);
         acc = 1'b1;
      end
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic idle(input int n, input logic rdy);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, idle_op, model(idle_op), rdy, 1'b0, acc);
   endtask

   task automatic push1(input op_t op, input exp_t ex);
      logic acc;
      cycle(1'b1, op, ex, 1'b1, 1'b0, acc);
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL accept cyc=%0d got in_ready=0 exp=1", cyc);
      end
   endtask

   task automatic check_empty(input string name);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s_drain got %0d pending exp 0", name, sb.size());
      end
   endtask

   task automatic check_flags(input string name, input logic [1:0] want);
      tests++;
      if (flags_o !== want) begin
         fails++;
         $display("FAIL %s got=%b exp=%b", name, flags_o, want);
      end
   endtask

   initial begin
      logic acc;
      op_t  o;
      int   pushed;
      logic pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      idle_op = mkop(0, 1'b0, 0, 24'h800000, 1'b0, 1'b0);

      vecs.push_back(mkv(mkop(0, 1'b0, 100, 24'h7FFFFE, 1'b1, 1'b0), 100, 24'h7FFFFE, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(0, 1'b0, 100, 24'hFFFFFF, 1'b1, 1'b1), 101, 24'h800000, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(0, 1'b0, 254, 24'hFFFFFF, 1'b1, 1'b0), 255, 24'h000000, 1'b1, 1'b1));
      vecs.push_back(mkv(mkop(1, 1'b0, 254, 24'hFFFFFF, 1'b1, 1'b0), 254, 24'hFFFFFF, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(2, 1'b1, 254, 24'hFFFFFF, 1'b1, 1'b0), 255, 24'h000000, 1'b1, 1'b1));
      vecs.push_back(mkv(mkop(3, 1'b1, 254, 24'hFFFFFF, 1'b1, 1'b0), 254, 24'hFFFFFF, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(3, 1'b0, 254, 24'hFFFFFF, 1'b0, 1'b1), 255, 24'h000000, 1'b1, 1'b1));
      vecs.push_back(mkv(mkop(1, 1'b0, 255, 24'h800000, 1'b0, 1'b0), 254, 24'hFFFFFF, 1'b1, 1'b1));
      vecs.push_back(mkv(mkop(0, 1'b0, 10, 24'h800001, 1'b1, 1'b0), 10, 24'h800002, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(4, 1'b0, 10, 24'h800000, 1'b1, 1'b0), 10, 24'h800001, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(5, 1'b0, 10, 24'h800000, 1'b1, 1'b1), 10, 24'h800000, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(0, 1'b1, -5, 24'hABCDEF, 1'b0, 1'b0), -5, 24'hABCDEF, 1'b0, 1'b0));
      vecs.push_back(mkv(mkop(2, 1'b0, 50, 24'hC00000, 1'b0, 1'b1), 50, 24'hC00000, 1'b1, 1'b0));
      vecs.push_back(mkv(mkop(7, 1'b1, 300, 24'h900000, 1'b0, 1'b0), 254, 24'hFFFFFF, 1'b1, 1'b1));
      vecs.push_back(mkv(mkop(0, 1'b1, 260, 24'h900000, 1'b0, 1'b0), 255, 24'h000000, 1'b1, 1'b1));

      // Reset state.
      repeat (3) @(negedge clk_i);
      tests++;
      if ({out_valid_o, out_exp_o, out_sig_o, out_inexact_o, out_overflow_o, flags_o} !== 39'd0) begin
         fails++;
         $display("FAIL reset_state got v=%b e=%h sig=%h f=%b exp all zero",
                  out_valid_o, out_exp_o, out_sig_o, flags_o);
      end
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Directed table, back to back at full throughput.
      lat_exact = 1'b1;
      foreach (vecs[i]) push1(vecs[i].op, vecs[i].ex);
      idle(4, 1'b1);
      check_empty("table");

      // Sticky flags: exact, inexact, then exact with clear on the retiring cycle.
      cycle(1'b0, idle_op, model(idle_op), 1'b1, 1'b1, acc);
      o = mkop(0, 1'b0, 20, 24'h812345, 1'b0, 1'b0);
      push1(o, model(o)); idle(3, 1'b1);
      check_flags("flags_exact", 2'b00);
      o = mkop(1, 1'b0, 20, 24'h812345, 1'b0, 1'b1);
      push1(o, model(o)); idle(3, 1'b1);
      check_flags("flags_inexact", 2'b01);
      clear_on_pop = 1'b1;
      o = mkop(0, 1'b1, 21, 24'h812346, 1'b0, 1'b0);
      push1(o, model(o)); idle(3, 1'b1);
      clear_on_pop = 1'b0;
      check_flags("flags_clear_hs", 2'b00);

      // Eight-operand stream against out_ready pattern 1,0,0,1.
      lat_exact = 1'b0;
      pops = 0;
      pushed = 0;
      o = rnd_op();
      for (int c = 0; c < 200 && (pushed < 8 || sb.size() != 0); c++) begin
         cycle(pushed < 8, o, model(o), pat[c % 4], 1'b0, acc);
         if (acc) begin
            pushed++;
            o = rnd_op();
         end
      end
      tests++;
      if (pushed != 8 || pops != 8) begin
         fails++;
         $display("FAIL stream got pushed=%0d popped=%0d exp 8/8", pushed, pops);
      end
      check_empty("stream");

      // Random traffic: first with a free-running consumer, then with random stalls.
      for (int c = 0; c < 600; c++) begin
         logic v, rdy, clr;
         lat_exact = (c < 300);
         v   = 1'($urandom_range(0, 3) != 0);
         rdy = (c < 300) ? 1'b1 : 1'($urandom_range(0, 1));
         clr = 1'($urandom_range(0, 15) == 0);
         o   = rnd_op();
         cycle(v, o, model(o), rdy, clr, acc);
      end
      lat_exact = 1'b0;
      idle(6, 1'b1);
      check_empty("random");

      // Reset while both stages hold operands.
      o = mkop(0, 1'b0, 30, 24'h800000, 1'b1, 1'b1);
      push1(o, model(o)); idle(3, 1'b1);
      for (int c = 0; c < 4; c++) cycle(1'b1, o, model(o), 1'b0, 1'b0, acc);
      tests++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || flags_o == 2'b00) begin
         fails++;
         $display("FAIL prefill got v=%b rdy=%b f=%b exp v=1 rdy=0 f!=0", out_valid_o, in_ready_o, flags_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      tests++;
      if (out_valid_o !== 1'b0 || flags_o !== 2'b00 || out_sig_o !== 24'd0) begin
         fails++;
         $display("FAIL mid_reset got v=%b f=%b sig=%h exp 0/00/0", out_valid_o, flags_o, out_sig_o);
      end
      sb.delete();
      flags_m = 2'b00;
      @(negedge clk_i);
      rst_ni = 1'b1;
      lat_exact = 1'b1;
      o = mkop(3, 1'b0, 40, 24'hFFFFFF, 1'b0, 1'b1);
      push1(o, model(o)); idle(4, 1'b1);
      check_empty("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
